// File: rtl/console_pkg.sv
// Shared constants and drain FSM encoding for the console receive path.
package console_pkg;

    localparam logic [31:0] UART_EMPTY_WORD    = 32'hFFFFFFFF;
    localparam int          CONSOLE_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        DRAIN_IDLE   = 2'd0,
        DRAIN_PULSE  = 2'd1,
        DRAIN_SETTLE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Register-file FIFO with explicit occupancy count; memory is not reset.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/console_rx_fifo.sv
// Drains simpleuart's single-byte register into a FIFO that the core pops
// with B3 semantics: head byte zero-extended, or zero when nothing is buffered.
module console_rx_fifo
    import console_pkg::*;
#(
    parameter int DEPTH = CONSOLE_FIFO_DEPTH,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   uart_dat_do,
    output logic          uart_dat_re,
    input  logic          cpu_dat_re,
    output logic [31:0]   cpu_dat_do,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          overrun_clr,
    output logic [7:0]    drop_count,
    output logic [1:0]    drain_state
);

    drain_state_t state;
    drain_state_t state_next;
    logic [7:0]   cap;
    logic         cap_load;
    logic [7:0]   head;
    logic         pop;
    logic         push;
    logic         drop;

    assign uart_dat_re = (state == DRAIN_PULSE);
    assign drain_state = state;
    assign pop         = cpu_dat_re && !empty;
    assign push        = uart_dat_re && (!full || pop);
    assign drop        = uart_dat_re && !push;
    assign cpu_dat_do  = empty ? 32'h0 : {24'h0, head};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DRAIN_IDLE;
            cap   <= '0;
        end else begin
            state <= state_next;
            if (cap_load) begin
                cap <= uart_dat_do[7:0];
            end
        end
    end

    // SETTLE gives simpleuart a cycle to drop its valid flag before IDLE looks again.
    always_comb begin
        state_next = state;
        cap_load   = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                if (uart_dat_do[31:8] == 24'h0) begin
                    cap_load   = 1'b1;
                    state_next = DRAIN_PULSE;
                end
            end
            DRAIN_PULSE:  state_next = DRAIN_SETTLE;
            DRAIN_SETTLE: state_next = DRAIN_IDLE;
            default:      state_next = DRAIN_IDLE;
        endcase
    end

    // A drop in the same cycle as overrun_clr leaves the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (cap),
        .dout   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_console_rx_fifo.sv
// Directed bench for console_rx_fifo with a simpleuart model and a read scoreboard.
module tb_console_rx_fifo;
    import console_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] uart_dat_do;
    logic        uart_dat_re;
    logic        cpu_dat_re;
    logic [31:0] cpu_dat_do;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overrun;
    logic        overrun_clr;
    logic [7:0]  drop_count;
    logic [1:0]  drain_state;

    int          vectors    = 0;
    int          miscompares = 0;
    int          pulse_cnt  = 0;
    int          p0;
    logic [7:0]  exp_q[$];

    console_rx_fifo dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_dat_do (uart_dat_do),
        .uart_dat_re (uart_dat_re),
        .cpu_dat_re  (cpu_dat_re),
        .cpu_dat_do  (cpu_dat_do),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .drop_count  (drop_count),
        .drain_state (drain_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // simpleuart model: byte presented, cleared to empty one cycle after the drain pulse.
    task automatic uart_send(input logic [7:0] b, input bit with_pop);
        bit got;
        @(posedge clk); #1;
        uart_dat_do = {24'h0, b};
        @(posedge clk); #1;
        if (with_pop) cpu_dat_re = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (uart_dat_re) got = 1'b1;
        end
        @(posedge clk); #1;
        uart_dat_do = UART_EMPTY_WORD;
        cpu_dat_re  = 1'b0;
        check("drain_pulse", {31'h0, got}, 32'h1);
    endtask

    task automatic cpu_read();
        @(posedge clk); #1;
        cpu_dat_re = 1'b1;
        @(posedge clk); #1;
        cpu_dat_re = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Monitor: pulse width and every cpu read against the expected queue.
    initial begin
        logic prev_re;
        logic [7:0] e;
        prev_re = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_dat_re) begin
                pulse_cnt++;
                check("re_width", {31'h0, prev_re}, 32'h0);
            end
            prev_re = uart_dat_re;
            if (cpu_dat_re) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rd_data", cpu_dat_do, {24'h0, e});
                end else begin
                    check("rd_empty", cpu_dat_do, 32'h0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        resetn      = 1'b0;
        uart_dat_do = UART_EMPTY_WORD;
        cpu_dat_re  = 1'b0;
        overrun_clr = 1'b0;
        wait_cycles(3);
        check("rst_re",      {31'h0, uart_dat_re}, 32'h0);
        check("rst_empty",   {31'h0, empty}, 32'h1);
        check("rst_full",    {31'h0, full}, 32'h0);
        check("rst_count",   {27'h0, count}, 32'h0);
        check("rst_dout",    cpu_dat_do, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_drops",   {24'h0, drop_count}, 32'h0);
        resetn = 1'b1;

        // Idle upstream: no drain activity.
        wait_cycles(50);
        check("idle_pulses", pulse_cnt, 0);
        check("idle_empty",  {31'h0, empty}, 32'h1);
        check("idle_dout",   cpu_dat_do, 32'h0);

        // Single byte round trip.
        exp_q.push_back(8'h41);
        uart_send(8'h41, 1'b0);
        @(negedge clk);
        check("one_pulses", pulse_cnt, 1);
        check("one_count",  {27'h0, count}, 32'h1);
        check("one_dout",   cpu_dat_do, 32'h41);
        cpu_read();
        @(negedge clk);
        check("one_count_after", {27'h0, count}, 32'h0);
        check("one_dout_after",  cpu_dat_do, 32'h0);

        // Fill to 16, then a 17th byte is drained and dropped.
        p0 = pulse_cnt;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h30 + 8'(i));
            uart_send(8'h30 + 8'(i), 1'b0);
        end
        @(negedge clk);
        check("fill_full",  {31'h0, full}, 32'h1);
        check("fill_count", {27'h0, count}, 32'd16);
        uart_send(8'h7A, 1'b0);
        @(negedge clk);
        check("drop_pulses",  pulse_cnt - p0, 17);
        check("drop_overrun", {31'h0, overrun}, 32'h1);
        check("drop_count1",  {24'h0, drop_count}, 32'h1);
        check("drop_keep",    {27'h0, count}, 32'd16);

        // Push and pop in the same cycle while full: push accepted.
        exp_q.push_back(8'h60);
        uart_send(8'h60, 1'b1);
        @(negedge clk);
        check("pp_count",   {27'h0, count}, 32'd16);
        check("pp_overrun", {31'h0, overrun}, 32'h1);
        check("pp_drops",   {24'h0, drop_count}, 32'h1);

        // Drop coinciding with overrun_clr: set wins.
        overrun_clr = 1'b1;
        uart_send(8'h7B, 1'b0);
        overrun_clr = 1'b0;
        @(negedge clk);
        check("clr_set_wins", {31'h0, overrun}, 32'h1);
        check("drop_count2",  {24'h0, drop_count}, 32'h2);
        @(posedge clk); #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("clr_overrun", {31'h0, overrun}, 32'h0);

        // Drain everything in order, then one read on empty.
        for (int i = 0; i < 16; i++) cpu_read();
        check("drain_empty_q", exp_q.size(), 0);
        cpu_read();
        @(negedge clk);
        check("drain_empty", {31'h0, empty}, 32'h1);
        check("drain_count", {27'h0, count}, 32'h0);

        // Interleaved traffic across the pointer wrap.
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'h80 + 8'(i));
            uart_send(8'h80 + 8'(i), 1'b0);
            cpu_read();
        end
        cpu_read();
        @(negedge clk);
        check("wrap_pulses", pulse_cnt - p0, 20);
        check("wrap_drops",  {24'h0, drop_count}, 32'h2);
        check("wrap_count",  {27'h0, count}, 32'h0);
        check("wrap_dout",   cpu_dat_do, 32'h0);

        // Build count=5 with overrun set, then reset in the middle of a drain pulse.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            uart_send(8'hA0 + 8'(i), 1'b0);
        end
        uart_send(8'hB0, 1'b0);
        for (int i = 0; i < 11; i++) cpu_read();
        @(negedge clk);
        check("pre_rst_count",   {27'h0, count}, 32'd5);
        check("pre_rst_overrun", {31'h0, overrun}, 32'h1);
        check("pre_rst_drops",   {24'h0, drop_count}, 32'h3);
        @(posedge clk); #1;
        uart_dat_do = 32'h0000_0099;
        @(posedge clk); #1;
        check("mid_pulse", {31'h0, uart_dat_re}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_re",      {31'h0, uart_dat_re}, 32'h0);
        check("arst_count",   {27'h0, count}, 32'h0);
        check("arst_empty",   {31'h0, empty}, 32'h1);
        check("arst_overrun", {31'h0, overrun}, 32'h0);
        check("arst_drops",   {24'h0, drop_count}, 32'h0);
        exp_q.delete();
        uart_dat_do = UART_EMPTY_WORD;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(2);
        exp_q.push_back(8'h5A);
        uart_send(8'h5A, 1'b0);
        @(negedge clk);
        check("post_rst_count", {27'h0, count}, 32'h1);
        check("post_rst_dout",  cpu_dat_do, 32'h5A);
        cpu_read();
        @(negedge clk);
        check("post_rst_empty", {31'h0, empty}, 32'h1);
        check("final_q", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/console_rx_fifo.md
Name: console_rx_fifo

Overview:
- Receive buffer between simpleuart's data register and the CPU core's B3 read-char instruction.
- simpleuart holds only one received byte, and the core polls it without blocking, so characters are lost while the core is busy.
- This block drains simpleuart autonomously into a small FIFO.
- The core reads from the FIFO with the same single-pulse, zero-when-empty semantics B3 already uses.

Parameters:
- DEPTH, 16, number of byte entries; power of two, at least 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock (16 MHz)
- resetn  in  1  asynchronous active-low reset
- uart_dat_do  in  32  simpleuart reg_dat_do; a byte is present when bits [31:8] are zero, and the value is 32'hFFFFFFFF when empty
- uart_dat_re  out  1  one-cycle pulse to simpleuart reg_dat_re; consumes the presented byte
- cpu_dat_re  in  1  one-cycle read/pop strobe from the core
- cpu_dat_do  out  32  head byte zero-extended, or 32'h0 when empty
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds DEPTH entries
- count  out  AW+1  current occupancy, 0..DEPTH
- overrun  out  1  sticky; a byte was dropped because the FIFO was full
- overrun_clr  in  1  clears overrun
- drop_count  out  8  bytes dropped since reset; saturates at 255

Behaviour:
- Reset (async assert, sync-safe deassert on clk edge):
  - uart_dat_re=0, pointers=0, count=0, empty=1, full=0, overrun=0, drop_count=0, cpu_dat_do=0, drain FSM=IDLE.
  - Memory contents are not reset.
  - A reset mid-operation discards all buffered bytes and any in-flight drain pulse.
- Drain FSM, 3 states:
  - IDLE: if uart_dat_do[31:8]==0, latch uart_dat_do[7:0] into cap, assert uart_dat_re for the next cycle, go to PULSE.
  - PULSE: uart_dat_re=1 this cycle only. Push cap if not full; otherwise drop it, set overrun, increment drop_count (saturating). Go to SETTLE.
  - SETTLE: uart_dat_re=0; one cycle so simpleuart clears its valid flag before it is sampled again. Go to IDLE.
  - Upstream throughput is one byte per 3 cycles, far above any baud rate.
- Full-FIFO policy: drain and drop the new byte; never stall simpleuart, whose own buffer would be overwritten anyway. Existing FIFO contents are never overwritten.
- Read side:
  - cpu_dat_do is combinational from mem[rd_ptr], zero-extended, forced to 0 when empty. Valid in the same cycle cpu_dat_re is sampled.
  - cpu_dat_re while non-empty: rd_ptr advances at the clock edge and count decrements.
  - cpu_dat_re while empty: ignored; no pointer change, no error flag.
  - The core samples cpu_dat_do in the same cycle it asserts cpu_dat_re, matching B3.
- Simultaneous push and pop:
  - Non-empty: both occur; count unchanged.
  - Full: pop frees a slot, so the push is accepted, not dropped.
  - Empty: pop ignored, push accepted; count becomes 1; cpu_dat_do that cycle is 0.
- Pointers:
  - AW-bit pointers wrap modulo DEPTH.
  - count is tracked explicitly.
  - full = (count==DEPTH); empty = (count==0).
- Overrun flag:
  - overrun_clr clears overrun.
  - If a drop coincides with overrun_clr, set wins.
  - drop_count is cleared only by reset.

Decomposition:
- Shared package (console_pkg) holds:
  - UART_EMPTY_WORD = 32'hFFFFFFFF
  - CONSOLE_FIFO_DEPTH = 16
  - the drain FSM state encoding (IDLE=0, PULSE=1, SETTLE=2)
- One natural sub-module: byte_fifo.
  - Generic register-file FIFO with push/pop/count/full/empty.
  - Same asynchronous active-low reset.
- console_rx_fifo contains the drain FSM, the overrun/drop logic, and the zero-when-empty output mux.

Test Plan:
- After reset, drive uart_dat_do=32'hFFFFFFFF for 50 cycles -> uart_dat_re never asserted, empty=1, cpu_dat_do=0.
- Present 8'h41 and model simpleuart clearing to FFFFFFFF one cycle after uart_dat_re -> exactly one 1-cycle uart_dat_re pulse, count=1, cpu_dat_do=32'h41; pulse cpu_dat_re -> count=0, cpu_dat_do=0.
- Push bytes 0x30..0x3F (16) with no reads -> full=1; a 17th byte 0x7A is drained (uart_dat_re pulses) and dropped -> overrun=1, drop_count=1; reads return 0x30..0x3F in order, then 0.
- With the FIFO full, push coincides with cpu_dat_re -> pop returns the head, new byte accepted, count stays 16, overrun unchanged.
- Push 20 bytes interleaved with 20 reads so pointers wrap -> data order preserved, no drops; cpu_dat_re on empty -> cpu_dat_do=0, count stays 0.
- Assert resetn low mid-PULSE with count=5 -> immediately uart_dat_re=0, count=0, empty=1, overrun=0; after release the next valid byte is drained normally.
